// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Phase, opcode and state encodings shared by the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam logic [2:0] c_PHASE_A1 = 3'd0;
    localparam logic [2:0] c_PHASE_A2 = 3'd1;
    localparam logic [2:0] c_PHASE_A3 = 3'd2;
    localparam logic [2:0] c_PHASE_M1 = 3'd3;
    localparam logic [2:0] c_PHASE_M2 = 3'd4;
    localparam logic [2:0] c_PHASE_X1 = 3'd5;
    localparam logic [2:0] c_PHASE_X2 = 3'd6;
    localparam logic [2:0] c_PHASE_X3 = 3'd7;

    localparam logic [3:0] c_OPR_JCN     = 4'h1;
    localparam logic [3:0] c_OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] c_OPR_JIN_FIN = 4'h3;
    localparam logic [3:0] c_OPR_JUN     = 4'h4;
    localparam logic [3:0] c_OPR_JMS     = 4'h5;
    localparam logic [3:0] c_OPR_ISZ     = 4'h7;
    localparam logic [3:0] c_OPR_BBL     = 4'hC;

    localparam logic [0:0] c_STATE_WORD1 = 1'b0;
    localparam logic [0:0] c_STATE_WORD2 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_op_classifier.sv
`default_nettype none
// ============================================================================
// Module   : op_classifier
// Purpose  : Classifies the first instruction word (two-word, JIN, BBL).
// Revision : 1.0 - initial release
// ============================================================================
module op_classifier
    import fetch_sequencer_pkg::*;
(
    input  logic [3:0] opr,
    input  logic       opaLsb,
    output logic       isTwoWord,
    output logic       isJin,
    output logic       isBbl
);

    always_comb begin
        isTwoWord = 1'b0;
        case (opr)
            c_OPR_JCN, c_OPR_JUN, c_OPR_JMS, c_OPR_ISZ: isTwoWord = 1'b1;
            // FIM and SRC share an OPR; only FIM (even OPA) carries data.
            c_OPR_FIM_SRC: isTwoWord = ~opaLsb;
            default:       isTwoWord = 1'b0;
        endcase
    end

    assign isJin = (opr == c_OPR_JIN_FIN) && opaLsb;
    assign isBbl = (opr == c_OPR_BBL);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Two-word instruction fetch FSM issuing PC, stack and pair strobes.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic [2:0]  cycle,
    input  logic [3:0]  romData,
    input  logic [11:0] pcAddr,
    input  logic        condTrue,
    input  logic        iszNonZero,
    input  logic [7:0]  pairDout,
    input  logic [11:0] stackTop,
    output logic [3:0]  oprOut,
    output logic [3:0]  opaOut,
    output logic        secondWord,
    output logic        pcLoad,
    output logic [11:0] pcNew,
    output logic        stackPush,
    output logic        stackPop,
    output logic        pairWe,
    output logic [3:0]  pairAddr,
    output logic [7:0]  pairDin
);

    logic [0:0]  r_state;
    logic [0:0]  w_nextState;
    logic [3:0]  r_opr1, r_opa1, r_opr2, r_opa2;
    logic        w_isTwoWord, w_isJin, w_isBbl;

    logic        w_pcLoad, w_stackPush, w_stackPop, w_pairWe;
    logic [11:0] w_pcNew;
    logic [3:0]  w_pairAddr;
    logic [7:0]  w_pairDin;
    logic        r_pcLoad, r_stackPush, r_stackPop, r_pairWe;
    logic [11:0] r_pcNew;
    logic [3:0]  r_pairAddr;
    logic [7:0]  r_pairDin;

    logic        w_unusedPcLow;
    assign w_unusedPcLow = ^pcAddr[7:0];

    op_classifier u_opClassifier (
        .opr       (r_opr1),
        .opaLsb    (r_opa1[0]),
        .isTwoWord (w_isTwoWord),
        .isJin     (w_isJin),
        .isBbl     (w_isBbl)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= c_STATE_WORD1;
        end else if (cycle == c_PHASE_X3) begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_STATE_WORD1: w_nextState = w_isTwoWord ? c_STATE_WORD2 : c_STATE_WORD1;
            default:       w_nextState = c_STATE_WORD1;
        endcase
    end

    // Opcode latches: first word while in WORD1, second word while in WORD2.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_opr1 <= 4'h0;
            r_opa1 <= 4'h0;
            r_opr2 <= 4'h0;
            r_opa2 <= 4'h0;
        end else if (r_state == c_STATE_WORD1) begin
            if (cycle == c_PHASE_M1) r_opr1 <= romData;
            if (cycle == c_PHASE_M2) r_opa1 <= romData;
        end else begin
            if (cycle == c_PHASE_M1) r_opr2 <= romData;
            if (cycle == c_PHASE_M2) r_opa2 <= romData;
        end
    end

    // Decoded during X2 so the registered strobes appear for exactly X3.
    always_comb begin
        w_pcLoad    = 1'b0;
        w_pcNew     = 12'h000;
        w_stackPush = 1'b0;
        w_stackPop  = 1'b0;
        w_pairWe    = 1'b0;
        w_pairAddr  = 4'h0;
        w_pairDin   = 8'h00;
        if (cycle == c_PHASE_X2) begin
            case (r_state)
                c_STATE_WORD1: begin
                    if (w_isJin) begin
                        w_pcLoad = 1'b1;
                        w_pcNew  = {pcAddr[11:8], pairDout};
                    end else if (w_isBbl) begin
                        w_pcLoad   = 1'b1;
                        w_stackPop = 1'b1;
                        w_pcNew    = stackTop;
                    end
                end
                default: begin
                    case (r_opr1)
                        c_OPR_JUN: begin
                            w_pcLoad = 1'b1;
                            w_pcNew  = {r_opa1, r_opr2, r_opa2};
                        end
                        c_OPR_JMS: begin
                            w_pcLoad    = 1'b1;
                            w_stackPush = 1'b1;
                            w_pcNew     = {r_opa1, r_opr2, r_opa2};
                        end
                        c_OPR_JCN: begin
                            if (condTrue) begin
                                w_pcLoad = 1'b1;
                                w_pcNew  = {pcAddr[11:8], r_opr2, r_opa2};
                            end
                        end
                        c_OPR_ISZ: begin
                            if (iszNonZero) begin
                                w_pcLoad = 1'b1;
                                w_pcNew  = {pcAddr[11:8], r_opr2, r_opa2};
                            end
                        end
                        c_OPR_FIM_SRC: begin
                            w_pairWe   = 1'b1;
                            w_pairAddr = {r_opa1[3:1], 1'b0};
                            w_pairDin  = {r_opr2, r_opa2};
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_pcLoad    <= 1'b0;
            r_pcNew     <= 12'h000;
            r_stackPush <= 1'b0;
            r_stackPop  <= 1'b0;
            r_pairWe    <= 1'b0;
            r_pairAddr  <= 4'h0;
            r_pairDin   <= 8'h00;
        end else begin
            r_pcLoad    <= w_pcLoad;
            r_pcNew     <= w_pcNew;
            r_stackPush <= w_stackPush;
            r_stackPop  <= w_stackPop;
            r_pairWe    <= w_pairWe;
            r_pairAddr  <= w_pairAddr;
            r_pairDin   <= w_pairDin;
        end
    end

    assign oprOut     = r_opr1;
    assign opaOut     = r_opa1;
    assign secondWord = (r_state == c_STATE_WORD2);
    assign pcLoad     = r_pcLoad;
    assign pcNew      = r_pcNew;
    assign stackPush  = r_stackPush;
    assign stackPop   = r_stackPop;
    assign pairWe     = r_pairWe;
    assign pairAddr   = r_pairAddr;
    assign pairDin    = r_pairDin;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  cycle;
    logic [3:0]  romData;
    logic [11:0] pcAddr;
    logic        condTrue;
    logic        iszNonZero;
    logic [7:0]  pairDout;
    logic [11:0] stackTop;
    logic [3:0]  oprOut, opaOut;
    logic        secondWord, pcLoad, stackPush, stackPop, pairWe;
    logic [11:0] pcNew;
    logic [3:0]  pairAddr;
    logic [7:0]  pairDin;

    always #5 clk = ~clk;

    fetch_sequencer u_dut (
        .clk        (clk),
        .rstN       (rstN),
        .cycle      (cycle),
        .romData    (romData),
        .pcAddr     (pcAddr),
        .condTrue   (condTrue),
        .iszNonZero (iszNonZero),
        .pairDout   (pairDout),
        .stackTop   (stackTop),
        .oprOut     (oprOut),
        .opaOut     (opaOut),
        .secondWord (secondWord),
        .pcLoad     (pcLoad),
        .pcNew      (pcNew),
        .stackPush  (stackPush),
        .stackPop   (stackPop),
        .pairWe     (pairWe),
        .pairAddr   (pairAddr),
        .pairDin    (pairDin)
    );

    int errCount   = 0;
    int checkCount = 0;

    // Snapshots: sSecond after the A1 edge, strobes during X3.
    logic        sSecond, sPcLoad, sPush, sPop, sWe, sStray, sRstSecond;
    logic [11:0] sPcNew;
    logic [3:0]  sAddr, sOpr, sOpa;
    logic [7:0]  sDin;
    logic [31:0] sRstAll;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic runPeriod(input logic [3:0] opr, input logic [3:0] opa, input int resetAt);
        sStray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle   = 3'(c);
            romData = (c == 3) ? opr : (c == 4) ? opa : 4'h0;
            rstN    = (c == resetAt) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (c == 0) sSecond = secondWord;
            if (c == resetAt) begin
                sRstSecond = secondWord;
                sRstAll = {oprOut, opaOut, pcLoad, stackPush, stackPop, pairWe,
                           pcNew[7:0], pairAddr, pairDin};
            end
            if (c == 6) begin
                sPcLoad = pcLoad;
                sPcNew  = pcNew;
                sPush   = stackPush;
                sPop    = stackPop;
                sWe     = pairWe;
                sAddr   = pairAddr;
                sDin    = pairDin;
                sOpr    = oprOut;
                sOpa    = opaOut;
            end else if (pcLoad || stackPush || stackPop || pairWe) begin
                sStray = 1'b1;
            end
        end
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b0; cycle = 3'd0; romData = 4'h0; pcAddr = 12'h000;
        condTrue = 1'b0; iszNonZero = 1'b0; pairDout = 8'h00; stackTop = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {oprOut, opaOut, secondWord, pcLoad, stackPush, stackPop, pairWe}, 32'h0);
        check("reset_data", {pcNew, pairAddr, pairDin}, 32'h0);

        // JUN 0x3A5
        runPeriod(4'h4, 4'h3, -1);
        check("jun_w1_second", sSecond, 1'b0);
        check("jun_w1_stray", sStray, 1'b0);
        check("jun_w1_load", sPcLoad, 1'b0);
        runPeriod(4'hA, 4'h5, -1);
        check("jun_second", sSecond, 1'b1);
        check("jun_load", sPcLoad, 1'b1);
        check("jun_pcnew", sPcNew, 12'h3A5);
        check("jun_push", sPush, 1'b0);
        check("jun_opr_hold", {sOpr, sOpa}, 8'h43);
        check("jun_stray", sStray, 1'b0);

        // JMS 0x123
        runPeriod(4'h5, 4'h1, -1);
        runPeriod(4'h2, 4'h3, -1);
        check("jms_push_load", {sPush, sPcLoad}, 2'b11);
        check("jms_pcnew", sPcNew, 12'h123);

        // JCN taken at last address of page 2
        pcAddr = 12'h2FF; condTrue = 1'b1; iszNonZero = 1'b0;
        runPeriod(4'h1, 4'h4, -1);
        runPeriod(4'h8, 4'h0, -1);
        check("jcn_t_second", sSecond, 1'b1);
        check("jcn_t_load", sPcLoad, 1'b1);
        check("jcn_t_pcnew", sPcNew, 12'h280);
        condTrue = 1'b0;
        runPeriod(4'h1, 4'h4, -1);
        runPeriod(4'h8, 4'h0, -1);
        check("jcn_nt_load", sPcLoad, 1'b0);
        check("jcn_nt_pcnew", sPcNew, 12'h000);
        check("jcn_nt_stray", sStray, 1'b0);
        runPeriod(4'h0, 4'h0, -1);
        check("jcn_next_word1", sSecond, 1'b0);
        check("nop_strobes", {sPcLoad, sPush, sPop, sWe}, 4'h0);

        // ISZ taken, page 7
        pcAddr = 12'h7C0; iszNonZero = 1'b1;
        runPeriod(4'h7, 4'h2, -1);
        runPeriod(4'h3, 4'h4, -1);
        check("isz_load", sPcLoad, 1'b1);
        check("isz_pcnew", sPcNew, 12'h734);
        iszNonZero = 1'b0;

        // FIM pair 6 <= 0xB7
        runPeriod(4'h2, 4'h6, -1);
        runPeriod(4'hB, 4'h7, -1);
        check("fim_we", sWe, 1'b1);
        check("fim_addr", sAddr, 4'h6);
        check("fim_din", sDin, 8'hB7);
        check("fim_load", sPcLoad, 1'b0);

        // BBL
        stackTop = 12'h456;
        runPeriod(4'hC, 4'h0, -1);
        check("bbl_second", sSecond, 1'b0);
        check("bbl_pop_load", {sPop, sPcLoad, sPush}, 3'b110);
        check("bbl_pcnew", sPcNew, 12'h456);
        runPeriod(4'h0, 4'h0, -1);
        check("bbl_next_second", sSecond, 1'b0);

        // JIN via pair contents
        pcAddr = 12'h5A0; pairDout = 8'h9C;
        runPeriod(4'h3, 4'h1, -1);
        check("jin_load_pop", {sPcLoad, sPop}, 2'b10);
        check("jin_pcnew", sPcNew, 12'h59C);

        // Reset in X1 of JUN second word
        runPeriod(4'h4, 4'h3, -1);
        runPeriod(4'hA, 4'h5, 5);
        check("rst_second", sRstSecond, 1'b0);
        check("rst_outputs", sRstAll, 32'h0);
        check("rst_no_load", sPcLoad, 1'b0);
        check("rst_stray", sStray, 1'b0);
        runPeriod(4'h0, 4'h0, -1);
        check("rst_next_second", sSecond, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
